uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 11 +
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_tx_frame.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM state encoding and frame-option constants shared by the UART TX serialiser.
package uart_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic STOP_ONE    = 1'b0;
  localparam logic STOP_TWO    = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter 0..P-1 (a prescale of 0 acts as 1); strobes on the last clock of each bit.
module uart_baud_tick #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  restart_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  bitEnd_o,
  output logic                  bitEndNext_o
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d, lastCnt;

  // bitEndNext_o looks one cycle ahead so the parent can register its frame-done pulse
  always_comb begin
    lastCnt = (prescale_i == '0) ? '0 : prescale_i - ONE;
    cnt_d   = (restart_i || (cnt_q == lastCnt)) ? '0 : cnt_q + ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bitEnd_o     = (cnt_q == lastCnt);
  assign bitEndNext_o = (cnt_d == lastCnt);

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART serialiser (start, DATA_W bits LSB first, optional parity, 1/2 stop bits), registered outputs.
// Define UART_TX_HOLD_EN to add a one-word holding register so back-to-back frames run without an idle gap.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     ParallelData,
  input  logic                  DataValid,
  input  logic                  ParityEn,
  input  logic                  ParityType,
  input  logic                  StopBits,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  TxDone,
  output logic                  TXOut
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  txState_e              state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [IDX_W-1:0]      bitIdx_q, bitIdx_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic parity_q, parity_d, parEn_q, parEn_d, stopTwo_q, stopTwo_d, stopIdx_q, stopIdx_d;
  logic ready_q, ready_d, busy_q, busy_d, txDone_q, txDone_d, txOut_q, txOut_d;
  logic accept, load, frameEnd, restart, bitEnd, bitEndNext;
  logic [DATA_W-1:0]     srcData;
  logic [PRESCALE_W-1:0] srcPs;
  logic srcPe, srcPt, srcSb;
`ifdef UART_TX_HOLD_EN
  logic                  holdValid_q, holdValid_d;
  logic [DATA_W-1:0]     holdData_q, holdData_d;
  logic [PRESCALE_W-1:0] holdPs_q, holdPs_d;
  logic holdPe_q, holdPe_d, holdPt_q, holdPt_d, holdSb_q, holdSb_d;
`endif

  uart_baud_tick #(.PRESCALE_W(PRESCALE_W)) uBaud (
    .clk_i       (CLK),
    .rst_i       (RST),
    .restart_i   (restart),
    .prescale_i  (prescale_q),
    .bitEnd_o    (bitEnd),
    .bitEndNext_o(bitEndNext)
  );

  // A buffered word always takes priority over the live inputs when a frame is loaded
  always_comb begin
    srcData = ParallelData;
    srcPe   = ParityEn;
    srcPt   = ParityType;
    srcSb   = StopBits;
    srcPs   = Prescale;
`ifdef UART_TX_HOLD_EN
    if (holdValid_q) begin
      srcData = holdData_q;
      srcPe   = holdPe_q;
      srcPt   = holdPt_q;
      srcSb   = holdSb_q;
      srcPs   = holdPs_q;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitIdx_d   = bitIdx_q;
    prescale_d = prescale_q;
    parity_d   = parity_q;
    parEn_d    = parEn_q;
    stopTwo_d  = stopTwo_q;
    stopIdx_d  = stopIdx_q;
    load       = 1'b0;
    accept     = DataValid && ready_q;
    frameEnd   = (state_q == STOP) && bitEnd && ((stopTwo_q == STOP_ONE) || stopIdx_q);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          load    = 1'b1;
        end
      end
      START: begin
        if (bitEnd) begin
          state_d  = DATA;
          bitIdx_d = '0;
        end
      end
      DATA: begin
        if (bitEnd) begin
          if (bitIdx_q == LAST_IDX) begin
            state_d   = parEn_q ? PARITY : STOP;
            stopIdx_d = 1'b0;
          end else begin
            bitIdx_d = bitIdx_q + IDX_ONE;
            shift_d  = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          state_d   = STOP;
          stopIdx_d = 1'b0;
        end
      end
      STOP: begin
        if (frameEnd) begin
`ifdef UART_TX_HOLD_EN
          if (holdValid_q || accept) begin
            state_d = START;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else if (bitEnd) begin
          stopIdx_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d    = srcData;
      parity_d   = (srcPt == PARITY_EVEN) ? ^srcData : ~^srcData;
      parEn_d    = srcPe;
      stopTwo_d  = srcSb;
      prescale_d = srcPs;
    end

`ifdef UART_TX_HOLD_EN
    holdValid_d = holdValid_q;
    holdData_d  = holdData_q;
    holdPe_d    = holdPe_q;
    holdPt_d    = holdPt_q;
    holdSb_d    = holdSb_q;
    holdPs_d    = holdPs_q;
    if (load && holdValid_q) begin
      holdValid_d = 1'b0;
    end
    // Ready implies the buffer is empty, so an accept that does not start a frame parks here
    if (accept && !load) begin
      holdValid_d = 1'b1;
      holdData_d  = ParallelData;
      holdPe_d    = ParityEn;
      holdPt_d    = ParityType;
      holdSb_d    = StopBits;
      holdPs_d    = Prescale;
    end
`endif
  end

  // Outputs are registered from next-state values so they change together with the state
  always_comb begin
    restart = (state_q == IDLE) || (state_d != state_q);
    case (state_d)
      START:   txOut_d = 1'b0;
      DATA:    txOut_d = shift_d[0];
      PARITY:  txOut_d = parity_d;
      default: txOut_d = 1'b1;
    endcase
    busy_d   = (state_d != IDLE);
    txDone_d = (state_d == STOP) && bitEndNext && ((stopTwo_d == STOP_ONE) || stopIdx_d);
`ifdef UART_TX_HOLD_EN
    ready_d  = !holdValid_d;
`else
    ready_d  = (state_d == IDLE);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bitIdx_q   <= '0;
      prescale_q <= '0;
      parity_q   <= 1'b0;
      parEn_q    <= 1'b0;
      stopTwo_q  <= 1'b0;
      stopIdx_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      txDone_q   <= 1'b0;
      txOut_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitIdx_q   <= bitIdx_d;
      prescale_q <= prescale_d;
      parity_q   <= parity_d;
      parEn_q    <= parEn_d;
      stopTwo_q  <= stopTwo_d;
      stopIdx_q  <= stopIdx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      txDone_q   <= txDone_d;
      txOut_q    <= txOut_d;
    end
  end

`ifdef UART_TX_HOLD_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      holdValid_q <= 1'b0;
      holdData_q  <= '0;
      holdPe_q    <= 1'b0;
      holdPt_q    <= 1'b0;
      holdSb_q    <= 1'b0;
      holdPs_q    <= '0;
    end else begin
      holdValid_q <= holdValid_d;
      holdData_q  <= holdData_d;
      holdPe_q    <= holdPe_d;
      holdPt_q    <= holdPt_d;
      holdSb_q    <= holdSb_d;
      holdPs_q    <= holdPs_d;
    end
  end
`endif

  assign Ready  = ready_q;
  assign Busy   = busy_q;
  assign TxDone = txDone_q;
  assign TXOut  = txOut_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: each accepted word pushes its expected per-cycle line state (TXOut, Busy, TxDone) to a
// scoreboard queue; a negedge monitor pops one entry per cycle and expects an idle line when the queue is empty.
`timescale 1ns/1ps
module tb_uart_tx_frame;

  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 6;
`ifdef UART_TX_HOLD_EN
  localparam logic EXP_READY_AFTER_ACCEPT = 1'b1;
`else
  localparam logic EXP_READY_AFTER_ACCEPT = 1'b0;
`endif

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [DATA_W-1:0]     ParallelData = '0;
  logic                  DataValid = 1'b0;
  logic                  ParityEn = 1'b0;
  logic                  ParityType = 1'b0;
  logic                  StopBits = 1'b0;
  logic [PRESCALE_W-1:0] Prescale = '0;
  logic                  Ready, Busy, TxDone, TXOut;

  typedef struct packed {
    logic txOut;
    logic busy;
    logic done;
  } lineExp_t;

  lineExp_t expQ[$];
  lineExp_t monE;
  int  vecCount  = 0;
  int  missCount = 0;
  bit  monEn     = 1'b0;

  uart_tx_frame #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ParallelData(ParallelData),
    .DataValid   (DataValid),
    .ParityEn    (ParityEn),
    .ParityType  (ParityType),
    .StopBits    (StopBits),
    .Prescale    (Prescale),
    .Ready       (Ready),
    .Busy        (Busy),
    .TxDone      (TxDone),
    .TXOut       (TXOut)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected waveform built from the bit list: start, data LSB first, parity, stop(s), each P cycles
  task automatic pushFrame(input logic [DATA_W-1:0] d, input logic pe, input logic pt, input logic sb,
                           input logic [PRESCALE_W-1:0] ps);
    logic bits[$];
    int   p;
    int   ones;
    p    = (ps == '0) ? 1 : int'(ps);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) begin
      bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    if (pe) bits.push_back(((ones % 2) == 1) ? !pt : pt);
    bits.push_back(1'b1);
    if (sb) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < p; c++) begin
        expQ.push_back('{txOut: bits[b], busy: 1'b1, done: ((b == bits.size() - 1) && (c == p - 1))});
      end
    end
  endtask

  always @(negedge CLK) begin
    if (monEn) begin
      if (expQ.size() > 0) monE = expQ.pop_front();
      else                 monE = '{txOut: 1'b1, busy: 1'b0, done: 1'b0};
      checkOutput("TXOut",  32'(TXOut),  32'(monE.txOut));
      checkOutput("Busy",   32'(Busy),   32'(monE.busy));
      checkOutput("TxDone", 32'(TxDone), 32'(monE.done));
    end
  end

  // Starts and returns at negedge+1; keep leaves DataValid high for a back-to-back follow-up word
  task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic pe, input logic pt, input logic sb,
                               input logic [PRESCALE_W-1:0] ps, input bit keep);
    int waitCnt;
    bit sent;
    waitCnt      = 0;
    sent         = 1'b0;
    ParallelData = d;
    ParityEn     = pe;
    ParityType   = pt;
    StopBits     = sb;
    Prescale     = ps;
    DataValid    = 1'b1;
    while (!sent) begin
      if (Ready) begin
        @(posedge CLK);
        pushFrame(d, pe, pt, sb, ps);
        sent = 1'b1;
      end else if (waitCnt >= 1000) begin
        checkOutput("readyTimeout", 32'(Ready), 32'(1));
        sent = 1'b1;
      end else begin
        waitCnt++;
        @(negedge CLK); #1;
      end
    end
    @(negedge CLK); #1;
    if (!keep) DataValid = 1'b0;
  endtask

  task automatic waitDrain();
    int cyc;
    cyc = 0;
    while (expQ.size() > 0 && cyc < 3000) begin
      @(negedge CLK); #1;
      cyc++;
    end
    if (expQ.size() > 0) checkOutput("drainTimeout", 32'(expQ.size()), 32'(0));
    repeat (2) begin
      @(negedge CLK); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("rstTXOut",  32'(TXOut),  32'(1));
    checkOutput("rstBusy",   32'(Busy),   32'(0));
    checkOutput("rstReady",  32'(Ready),  32'(1));
    checkOutput("rstTxDone", 32'(TxDone), 32'(0));
    RST   = 1'b0;
    monEn = 1'b1;
    repeat (2) begin
      @(negedge CLK); #1;
    end

    // 0xA5, one-cycle bits, no parity, one stop bit
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 6'd1, 1'b0);
    checkOutput("readyAfterAccept", 32'(Ready), 32'(EXP_READY_AFTER_ACCEPT));
    waitDrain();

    // Prescale 4 with parity and two stop bits; inputs change mid-frame
    applyStimulus(8'h0F, 1'b1, 1'b0, 1'b1, 6'd4, 1'b0);
    ParallelData = 8'hFF;
    ParityType   = 1'b1;
    StopBits     = 1'b0;
    Prescale     = 6'd1;
    waitDrain();
    applyStimulus(8'h07, 1'b1, 1'b1, 1'b1, 6'd4, 1'b0);
    waitDrain();
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, 6'd4, 1'b0);
    waitDrain();

    // Prescale 0 behaves as 1; DataValid held high across two words
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    waitDrain();

`ifdef UART_TX_HOLD_EN
    // Two words back-to-back at P=2: second is buffered, Ready returns at its START
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 6'd2, 1'b1);
    applyStimulus(8'hAA, 1'b0, 1'b0, 1'b0, 6'd2, 1'b0);
    checkOutput("holdReadyLow", 32'(Ready), 32'(0));
    repeat (18) begin
      @(negedge CLK); #1;
    end
    checkOutput("holdReadyLastStop", 32'(Ready), 32'(0));
    @(negedge CLK); #1;
    checkOutput("holdReadySecondStart", 32'(Ready), 32'(1));
    waitDrain();
`endif

    // Reset in the middle of the data bits of 0xFF, then a clean frame
    applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, 6'd2, 1'b0);
    repeat (4) begin
      @(negedge CLK); #1;
    end
    monEn = 1'b0;
    expQ.delete();
    RST = 1'b1;
    @(negedge CLK); #1;
    checkOutput("midRstTXOut",  32'(TXOut),  32'(1));
    checkOutput("midRstBusy",   32'(Busy),   32'(0));
    checkOutput("midRstReady",  32'(Ready),  32'(1));
    checkOutput("midRstTxDone", 32'(TxDone), 32'(0));
    RST   = 1'b0;
    monEn = 1'b1;
    @(negedge CLK); #1;
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0, 6'd3, 1'b0);
    waitDrain();

    monEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
